// File: rtl/cmd_parser.sv
// cmd_parser: decodes ASCII "<hexA><op><hexB>=" commands into operands and an opcode for the ALU
module cmd_parser #(
  parameter int OP_W = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [OP_W-1:0] op_a,
  output logic [OP_W-1:0] op_b,
  output logic [1:0]      opcode,
  output logic            parser_done,
  output logic            parse_err
);
  localparam int MAX_DIGITS = OP_W / 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  typedef enum logic [1:0] {S_A, S_B, S_ERR} state_t;
  state_t          r_state;
  logic [OP_W-1:0] r_acc_a, r_acc_b;
  logic [CW-1:0]   r_cnt_a, r_cnt_b;
  logic [1:0]      r_op;
  logic            w_dec, w_digit, w_op, w_eq, w_sp, w_full_a, w_full_b;
  logic [3:0]      w_nib;
  logic [1:0]      w_op_code;
  assign w_dec     = rx_data inside {[8'h30:8'h39]};
  assign w_digit   = w_dec || (rx_data inside {[8'h41:8'h46], [8'h61:8'h66]});
  assign w_nib     = w_dec ? rx_data[3:0] : rx_data[3:0] + 4'd9;
  assign w_op      = rx_data inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
  assign w_op_code = rx_data == 8'h2D ? 2'd1 : rx_data == 8'h2A ? 2'd2 : rx_data == 8'h2F ? 2'd3 : 2'd0;
  assign w_eq      = rx_data == 8'h3D;
  assign w_sp      = rx_data == 8'h20;
  assign w_full_a  = r_cnt_a == CW'(MAX_DIGITS);
  assign w_full_b  = r_cnt_b == CW'(MAX_DIGITS);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_A;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_op        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      opcode      <= '0;
      parser_done <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      parser_done <= 1'b0;
      parse_err   <= 1'b0;
      if (rx_valid && !w_sp) begin
        case (r_state)
          S_A: begin
            if (w_digit && !w_full_a) begin
              r_acc_a <= {r_acc_a[OP_W-5:0], w_nib};
              r_cnt_a <= r_cnt_a + CW'(1);
            end else if (w_op && r_cnt_a != '0) begin
              r_op    <= w_op_code;
              r_state <= S_B;
            end else begin
              parse_err <= 1'b1;
              r_acc_a   <= '0;
              r_acc_b   <= '0;
              r_cnt_a   <= '0;
              r_cnt_b   <= '0;
              r_state   <= w_eq ? S_A : S_ERR;
            end
          end
          S_B: begin
            if (w_digit && !w_full_b) begin
              r_acc_b <= {r_acc_b[OP_W-5:0], w_nib};
              r_cnt_b <= r_cnt_b + CW'(1);
            end else if (w_eq && r_cnt_b != '0) begin
              op_a        <= r_acc_a;
              op_b        <= r_acc_b;
              opcode      <= r_op;
              parser_done <= 1'b1;
              r_acc_a     <= '0;
              r_acc_b     <= '0;
              r_cnt_a     <= '0;
              r_cnt_b     <= '0;
              r_state     <= S_A;
            end else begin
              parse_err <= 1'b1;
              r_acc_a   <= '0;
              r_acc_b   <= '0;
              r_cnt_a   <= '0;
              r_cnt_b   <= '0;
              r_state   <= w_eq ? S_A : S_ERR;
            end
          end
          // accumulators were cleared on entry; only the terminator matters here
          S_ERR: r_state <= w_eq ? S_A : S_ERR;
          default: r_state <= S_A;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed and random commands against a string-grammar reference model
module tb_cmd_parser;
  typedef logic [7:0] u8;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] op_a, op_b;
  logic [1:0]  opcode;
  logic        parser_done, parse_err;
  int          n_chk = 0;
  int          n_fail = 0;
  u8           q[$];
  bit          m_err = 0;
  logic [31:0] e_a = '0, e_b = '0;
  logic [1:0]  e_op = '0;
  bit          e_done = 0, e_perr = 0;

  cmd_parser #(.OP_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .parser_done(parser_done), .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hex(u8 c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic int hexval(u8 c);
    if (c <= 8'h39) return int'(c) - 48;
    if (c <= 8'h46) return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic int op_index(u8 c);
    case (c)
      8'h2B: return 0;
      8'h2D: return 1;
      8'h2A: return 2;
      8'h2F: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int count_hex(int from);
    int n = 0;
    while (from + n < q.size() && is_hex(q[from + n])) n++;
    return n;
  endfunction

  // 0: no longer a prefix of hex{1,8} op hex{1,8} '=', 1: valid prefix, 2: complete command
  function automatic int classify();
    int na, nb, j;
    na = count_hex(0);
    if (na > 8) return 0;
    if (na == q.size()) return 1;
    if (na == 0 || op_index(q[na]) < 0) return 0;
    j = na + 1;
    nb = count_hex(j);
    if (nb > 8) return 0;
    if (j + nb == q.size()) return 1;
    if (nb > 0 && q[j + nb] == 8'h3D && j + nb + 1 == q.size()) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] value(int from, int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v * 16 + 32'(hexval(q[from + i]));
    return v;
  endfunction

  task automatic model(input u8 c);
    int r, na;
    if (c == 8'h20) return;
    if (m_err) begin
      if (c == 8'h3D) m_err = 0;
      return;
    end
    q.push_back(c);
    r = classify();
    if (r == 0) begin
      e_perr = 1;
      m_err = (c != 8'h3D);
      q.delete();
    end else if (r == 2) begin
      na = count_hex(0);
      e_a = value(0, na);
      e_b = value(na + 1, count_hex(na + 1));
      e_op = 2'(op_index(q[na]));
      e_done = 1;
      q.delete();
    end
  endtask

  task automatic tick(input bit v, input u8 c);
    rx_valid = v;
    rx_data = c;
    e_done = 0;
    e_perr = 0;
    if (v) model(c);
    @(negedge clk);
    check("parser_done", 64'(parser_done), 64'(e_done));
    check("parse_err", 64'(parse_err), 64'(e_perr));
    check("op_a", 64'(op_a), 64'(e_a));
    check("op_b", 64'(op_b), 64'(e_b));
    check("opcode", 64'(opcode), 64'(e_op));
  endtask

  task automatic send_q(input u8 b[$], input int gap_pct);
    foreach (b[i]) begin
      if ($urandom_range(0, 99) < gap_pct) tick(0, u8'($urandom));
      tick(1, b[i]);
    end
    tick(0, 8'h00);
  endtask

  task automatic send_s(input string s);
    u8 b[$];
    for (int i = 0; i < s.len(); i++) b.push_back(u8'(s[i]));
    send_q(b, 0);
  endtask

  function automatic u8 rand_hex();
    int d = $urandom_range(0, 15);
    if (d < 10) return u8'(48 + d);
    return u8'(($urandom_range(0, 1) ? 65 : 97) + d - 10);
  endfunction

  function automatic u8 rand_op();
    u8 ops[4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    return ops[$urandom_range(0, 3)];
  endfunction

  task automatic apply_reset();
    #2 n_rst = 1'b0;
    q.delete();
    m_err = 0;
    e_a = '0;
    e_b = '0;
    e_op = '0;
    #1;
    check("rst_op_a", 64'(op_a), 64'(0));
    check("rst_op_b", 64'(op_b), 64'(0));
    check("rst_opcode", 64'(opcode), 64'(0));
    check("rst_done", 64'(parser_done), 64'(0));
    check("rst_err", 64'(parse_err), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    u8 b[$];
    int na, nb;
    @(negedge clk);
    apply_reset();
    tick(0, 8'h00);
    send_s("1A+2F=");
    send_s(" ff * 3 =");
    send_s("123456789+1=");
    send_s("8-1=");
    send_s("+5=");
    send_s("5/=");
    send_s("5+-3=");
    send_s("7*2=");
    send_s("FFFFFFFF/FFFFFFFF=");
    send_s("abcdef01-9=");
    send_s("1+123456789=");
    send_s("=");
    send_s("12+");
    apply_reset();
    send_s("4+4=");
    for (int k = 0; k < 300; k++) begin
      b.delete();
      na = $urandom_range(0, 4) == 0 ? $urandom_range(0, 9) : $urandom_range(1, 8);
      nb = $urandom_range(0, 4) == 0 ? $urandom_range(0, 9) : $urandom_range(1, 8);
      for (int i = 0; i < na; i++) b.push_back(rand_hex());
      b.push_back(rand_op());
      for (int i = 0; i < nb; i++) b.push_back(rand_hex());
      b.push_back(8'h3D);
      if ($urandom_range(0, 4) == 0) b.insert($urandom_range(0, b.size() - 1), 8'h20);
      if ($urandom_range(0, 9) == 0) b.insert($urandom_range(0, b.size() - 1), u8'($urandom_range(0, 255)));
      if ($urandom_range(0, 19) == 0) b.insert($urandom_range(0, b.size() - 1), rand_op());
      send_q(b, $urandom_range(0, 1) ? 0 : 30);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
